// File: rtl/router_rx_sink.sv
// router_rx_sink: deserialises one router output port into a byte stream
// with packet boundaries, buffered in a show-ahead FIFO.
module router_rx_sink #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_n,
  input  logic        valid_n,
  input  logic        din,
  output logic [7:0]  byte_data,
  output logic        byte_last,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [15:0] pkt_count,
  output logic        err_partial,
  output logic        err_overflow,
  input  logic        clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    RECV
  } state_t;

  state_t state;
  state_t state_nx;

  logic         sample;
  logic         end_cyc;
  logic         bit_in;
  logic         byte_done;
  logic         leftover;
  logic [2:0]   bit_cnt;
  logic [2:0]   cnt_nx;
  logic [7:0]   shreg;
  logic [7:0]   new_byte;

  logic         pend_valid;
  logic         pend_last;
  logic [7:0]   pend_data;

  logic         push;
  logic         push_last;
  logic         pop;
  logic         full;
  logic         empty;
  logic         wr_en;
  logic         drop;
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [8:0]   mem [FIFO_DEPTH];
  logic [8:0]   head;

  always_ff @(posedge clock) begin
    if (reset) state <= SYNC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SYNC:    if (frame_n)  state_nx = IDLE;
      IDLE:    if (!frame_n) state_nx = RECV;
      RECV:    if (frame_n)  state_nx = IDLE;
      default: state_nx = SYNC;
    endcase
  end

  always_comb begin
    sample  = 1'b0;
    end_cyc = 1'b0;
    case (state)
      IDLE: sample = !frame_n;
      RECV: begin
        sample  = 1'b1;
        end_cyc = frame_n;
      end
      default: ;
    endcase
  end

  assign bit_in    = sample && !valid_n;
  assign cnt_nx    = bit_in ? bit_cnt + 3'd1 : bit_cnt;
  assign byte_done = bit_in && (bit_cnt == 3'd7);
  assign new_byte  = {din, shreg[7:1]};
  assign leftover  = end_cyc && (cnt_nx != 3'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (bit_in) shreg <= new_byte;
      bit_cnt <= end_cyc ? 3'd0 : cnt_nx;
    end
  end

  // A completing byte flushes the pending one as non-final; a pending
  // byte already marked final drains on the next idle opportunity.
  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    unique case (1'b1)
      byte_done && pend_valid: push = 1'b1;
      !byte_done && pend_valid && pend_last: begin
        push      = 1'b1;
        push_last = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
      pend_data  <= 8'h00;
    end else if (byte_done) begin
      pend_valid <= 1'b1;
      pend_last  <= end_cyc;
      pend_data  <= new_byte;
    end else if (push) begin
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
    end else if (end_cyc && pend_valid) begin
      pend_last  <= 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && byte_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {push_last, pend_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count    <= 16'd0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (push && push_last) pkt_count <= pkt_count + 16'd1;
      if (leftover)     err_partial <= 1'b1;
      else if (clr_err) err_partial <= 1'b0;
      if (drop)         err_overflow <= 1'b1;
      else if (clr_err) err_overflow <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign byte_valid = !empty;
  assign byte_data  = byte_valid ? head[7:0] : 8'h00;
  assign byte_last  = byte_valid ? head[8] : 1'b0;

endmodule

// File: tb/tb_router_rx_sink.sv
// tb_router_rx_sink: directed stimulus with a byte scoreboard for
// router_rx_sink, instantiated with a 4-entry FIFO.
module tb_router_rx_sink;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_n;
  logic        valid_n;
  logic        din;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] pkt_count;
  logic        err_partial;
  logic        err_overflow;
  logic        clr_err;

  int errors = 0;
  int checks = 0;
  logic [8:0] sbq [$];

  router_rx_sink #(.FIFO_DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_n      (frame_n),
    .valid_n      (valid_n),
    .din          (din),
    .byte_data    (byte_data),
    .byte_last    (byte_last),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .pkt_count    (pkt_count),
    .err_partial  (err_partial),
    .err_overflow (err_overflow),
    .clr_err      (clr_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic l);
    sbq.push_back({l, d});
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n,
                           input int gap);
    for (int i = 0; i < n; i++) begin
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          frame_n = 1'b0;
          valid_n = 1'b1;
          din     = 1'b0;
          tick();
        end
      end
      frame_n = (i == n - 1);
      valid_n = 1'b0;
      din     = bits[i];
      tick();
    end
    frame_n = 1'b1;
    valid_n = 1'b1;
    din     = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) tick();
    chk("drain", sbq.size(), 0);
    tick();
    chk("empty_after_drain", byte_valid, 1'b0);
  endtask

  always @(negedge clock) begin
    if (!reset && !byte_valid)
      chk("idle_outputs_zero", {byte_last, byte_data}, 9'h000);
    if (!reset && byte_valid && byte_ready) begin
      if (sbq.size() == 0) chk("unexpected_byte", {byte_last, byte_data}, 9'h1ff);
      else chk("sb_byte", {byte_last, byte_data}, sbq.pop_front());
    end
  end

  initial begin
    reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0;
    byte_ready = 1'b1; clr_err = 1'b0;
    tick(); tick();
    chk("rst_valid", byte_valid, 1'b0);
    chk("rst_data", byte_data, 8'h00);
    chk("rst_last", byte_last, 1'b0);
    chk("rst_pkt", pkt_count, 16'd0);
    chk("rst_errs", {err_partial, err_overflow}, 2'b00);
    reset = 1'b0;
    tick(); tick();

    expect_byte(8'hA5, 1'b0);
    expect_byte(8'h3C, 1'b1);
    send_bits({48'h0, 8'h3C, 8'hA5}, 16, 0);
    chk("a_head_first", {byte_valid, byte_last, byte_data}, 10'h2A5);
    tick();
    chk("a_head_last", {byte_valid, byte_last, byte_data}, 10'h33C);
    chk("a_pkt", pkt_count, 16'd1);
    wait_drain();
    chk("a_errs", {err_partial, err_overflow}, 2'b00);

    expect_byte(8'hA5, 1'b0);
    expect_byte(8'h3C, 1'b1);
    send_bits({48'h0, 8'h3C, 8'hA5}, 16, 2);
    wait_drain();
    chk("b_pkt", pkt_count, 16'd2);
    chk("b_errs", {err_partial, err_overflow}, 2'b00);

    expect_byte(8'h81, 1'b1);
    send_bits({53'h0, 3'b101, 8'h81}, 11, 0);
    chk("c_partial", err_partial, 1'b1);
    chk("c_pkt_before", pkt_count, 16'd2);
    tick();
    chk("c_pkt", pkt_count, 16'd3);
    wait_drain();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("c_partial_clr", err_partial, 1'b0);

    expect_byte(8'h5A, 1'b1);
    expect_byte(8'hC3, 1'b0);
    expect_byte(8'h7E, 1'b1);
    send_bits({56'h0, 8'h5A}, 8, 0);
    send_bits({48'h0, 8'h7E, 8'hC3}, 16, 0);
    wait_drain();
    chk("d_pkt", pkt_count, 16'd5);

    byte_ready = 1'b0;
    for (int b = 1; b <= 4; b++) expect_byte(8'(b), 1'b0);
    send_bits({16'h0, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 48, 0);
    chk("e_overflow", err_overflow, 1'b1);
    tick();
    chk("e_pkt", pkt_count, 16'd6);
    chk("e_head", {byte_valid, byte_last, byte_data}, 10'h201);
    byte_ready = 1'b1;
    wait_drain();
    chk("e_overflow_held", err_overflow, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("e_overflow_clr", err_overflow, 1'b0);

    byte_ready = 1'b0;
    send_bits({56'h0, 8'h99}, 8, 0);
    tick(); tick();
    chk("f_prefill", byte_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      frame_n = 1'b0; valid_n = 1'b0; din = 1'($urandom);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    byte_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame_n = 1'b0; valid_n = 1'b0; din = 1'($urandom);
      tick();
    end
    frame_n = 1'b1; din = 1'b1;
    tick();
    valid_n = 1'b1; din = 1'b0;
    tick(); tick(); tick();
    chk("f_no_bytes", byte_valid, 1'b0);
    chk("f_pkt_zero", pkt_count, 16'd0);
    chk("f_errs", {err_partial, err_overflow}, 2'b00);
    expect_byte(8'hE7, 1'b1);
    send_bits({56'h0, 8'hE7}, 8, 0);
    tick();
    wait_drain();
    chk("f_pkt", pkt_count, 16'd1);

    chk("sb_leftover", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
